// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers for the multicycle MIPS datapath.
// One radix-2 step per cycle: shift-add multiply, restoring divide, then a sign-fix cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     counter;
  logic                 is_div;
  logic                 neg_lo, neg_hi;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   acc;

  logic                 signed_op, sign1, sign2, div_zero;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       mul_sum, rem_shift, rem_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign Busy = (state != IDLE);

  // Operand magnitudes and result signs captured at launch.
  assign signed_op = ~Op[0];
  assign sign1     = signed_op & In1[WIDTH-1];
  assign sign2     = signed_op & In2[WIDTH-1];
  assign div_zero  = Op[1] & (In2 == '0);
  // With a zero divisor the restoring loop yields an all-ones quotient and
  // returns the dividend as remainder, so feeding the raw In1 unsigned gives LO/HI directly.
  assign mag1      = (sign1 && !div_zero) ? -In1 : In1;
  assign mag2      = sign2 ? -In2 : In2;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd};
    if (rem_shift >= {1'b0, opnd}) begin
      div_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
    prod_fix = neg_lo ? -acc : acc;
    quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: next-state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = CALC;
      CALC:    if (counter == CNT_W'(ITER - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the operand and accumulator registers are reset along with the
  // architectural state so the unit powers up fully deterministic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      counter <= '0;
      Hi      <= '0;
      Lo      <= '0;
      Done    <= 1'b0;
      is_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (HiWrite) Hi <= WriteData;
          if (LoWrite) Lo <= WriteData;
          if (Start) begin
            counter <= '0;
            is_div  <= Op[1];
            if (Op[1]) begin
              opnd   <= mag2;
              acc    <= {{WIDTH{1'b0}}, mag1};
              neg_lo <= (sign1 ^ sign2) & ~div_zero;
              neg_hi <= sign1 & ~div_zero;
            end else begin
              opnd   <= mag1;
              acc    <= {{WIDTH{1'b0}}, mag2};
              neg_lo <= sign1 ^ sign2;
              neg_hi <= 1'b0;
            end
          end
        end
        CALC: begin
          acc     <= is_div ? div_next : mul_next;
          counter <= counter + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            Hi <= rem_fix;
            Lo <= quo_fix;
          end else begin
            Hi <= prod_fix[2*WIDTH-1:WIDTH];
            Lo <= prod_fix[WIDTH-1:0];
          end
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO queued at launch, compared on each Done pulse.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] In1, In2;
  logic        HiWrite, LoWrite;
  logic [31:0] WriteData;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  logic [63:0] exp_q[$];

  mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .In1(In1), .In2(In2),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operation's definition.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    int     sq, sr;
    case (op)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every Done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && Done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 with Hi=%h Lo=%h, expected no result pending", Hi, Lo);
      end else begin
        check("result", {Hi, Lo}, exp_q.pop_front());
      end
    end
  end

  // Call away from a rising edge; the next rising edge becomes E0.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    Start = 1'b1;
    Op    = op;
    In1   = a;
    In2   = b;
    if (push) exp_q.push_back(ref_model(op, a, b));
    @(posedge clk);
    #1;
    Start = 1'b0;
    In1   = $urandom;
    In2   = $urandom;
  endtask

  // Counts falling edges after E0 until Done; optionally injects ignored traffic while busy.
  task automatic wait_done(input bit noise, output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (Busy) busy_n++;
      if (Done) break;
      if (noise) begin
        Start     = ($urandom_range(0, 7) == 0);
        Op        = 2'($urandom);
        In1       = $urandom;
        In2       = $urandom;
        HiWrite   = ($urandom_range(0, 3) == 0);
        LoWrite   = ($urandom_range(0, 3) == 0);
        WriteData = $urandom;
      end
    end
    Start   = 1'b0;
    HiWrite = 1'b0;
    LoWrite = 1'b0;
    if (!Done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no Done within %0d cycles, expected Done", lat);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] spec_val);
    int lat, busy_n;
    issue(op, a, b, 1'b1);
    wait_done(1'b0, lat, busy_n);
    check({name, "_latency"}, lat, 34);
    check({name, "_busy_cycles"}, busy_n, 33);
    check({name, "_value"}, {Hi, Lo}, spec_val);
    @(negedge clk);
    check({name, "_done_width"}, Done, 1'b0);
  endtask

  initial begin
    int lat, busy_n, d0;
    logic [1:0] op;
    logic [31:0] a, b;

    reset     = 1'b0;
    Start     = 1'b1;
    Op        = 2'b01;
    In1       = 32'h1234_5678;
    In2       = 32'h9ABC_DEF0;
    HiWrite   = 1'b0;
    LoWrite   = 1'b0;
    WriteData = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", Busy, 1'b0);
    check("reset_done", Done, 1'b0);
    check("reset_hilo", {Hi, Lo}, 64'h0);
    reset = 1'b1;
    Start = 1'b0;
    @(negedge clk);

    // Abort in CALC: reset must discard the operation without a Done.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (10) @(negedge clk);
    check("abort_busy_before", Busy, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("abort_busy_after", Busy, 1'b0);
    check("abort_hilo", {Hi, Lo}, 64'h0);
    repeat (40) @(negedge clk);
    check("abort_no_done", done_count, 0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu",      2'b11, 32'h8000_0000, 32'd3,         64'h0000_0002_2AAA_AAAA);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op("div_zero",  2'b10, 32'h1234_5678, 32'h0,         64'h1234_5678_FFFF_FFFF);

    // Start and MTHI while busy are ignored; exactly one Done results.
    d0 = done_count;
    issue(2'b11, 32'h8000_0000, 32'd3, 1'b1);
    repeat (5) @(negedge clk);
    Start     = 1'b1;
    Op        = 2'b00;
    In1       = 32'd100;
    In2       = 32'd200;
    HiWrite   = 1'b1;
    WriteData = 32'hDEAD_BEEF;
    @(negedge clk);
    Start   = 1'b0;
    HiWrite = 1'b0;
    wait_done(1'b0, lat, busy_n);
    check("busy_ignore_value", {Hi, Lo}, 64'h0000_0002_2AAA_AAAA);
    repeat (40) @(negedge clk);
    check("busy_single_done", done_count - d0, 1);

    // MTHI / MTLO in IDLE.
    HiWrite   = 1'b1;
    WriteData = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    HiWrite = 1'b0;
    check("mthi_idle", Hi, 32'hDEAD_BEEF);
    LoWrite   = 1'b1;
    WriteData = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    LoWrite = 1'b0;
    check("mtlo_idle", {Hi, Lo}, 64'hDEAD_BEEF_0BAD_F00D);
    @(negedge clk);

    // MTHI together with Start: written now, overwritten by the result.
    HiWrite   = 1'b1;
    WriteData = 32'hCAFE_F00D;
    issue(2'b01, 32'd6, 32'd7, 1'b1);
    HiWrite = 1'b0;
    check("mthi_with_start", Hi, 32'hCAFE_F00D);
    wait_done(1'b0, lat, busy_n);
    check("mthi_overwritten", {Hi, Lo}, 64'd42);

    // Random back-to-back operations: each Start is issued in the previous Done cycle.
    for (int n = 0; n < 1500; n++) begin
      op = 2'($urandom);
      a  = rand_opnd();
      b  = rand_opnd();
      issue(op, a, b, 1'b1);
      wait_done(1'b1, lat, busy_n);
      check("rand_latency", lat, 34);
    end
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
